// File: rtl/connect_lane_reducer_if.sv
`default_nettype none
// ============================================================================
//  Module   : connect_lane_reducer_if
//  Brief    : Handshake/data bundle for connect_lane_reducer (input beat with
//             mode/mask side-band, registered ready/valid result, beat count).
//  Revision : 1.0 - initial release
// ============================================================================
interface connect_lane_reducer_if #(
    parameter int WIDTH = 1,
    parameter int LANES = 2
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_bits;
    logic [1:0]       io_mode;
    logic [LANES-1:0] io_lane_en;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_bits;
    logic [15:0]      io_beats;

    // Producer/consumer side: offers beats, takes results.
    modport master (
        output io_in_valid, io_in_bits, io_mode, io_lane_en, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_beats
    );

    // Block side.
    modport slave (
        input  io_in_valid, io_in_bits, io_mode, io_lane_en, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_beats
    );
endinterface
`default_nettype wire

// File: rtl/connect_lane_reducer.sv
`default_nettype none
// ============================================================================
//  Module   : connect_lane_reducer
//  Brief    : Fans the input word out to LANES pass-through lanes, reduces the
//             enabled lanes with OR/AND/XOR (or bypasses them), folds in the
//             value accepted DELAY beats earlier, and registers the result
//             behind a single-stage, bubble-free ready/valid output.
//  Revision : 1.0 - initial release
// ============================================================================
module connect_lane_reducer #(
    parameter int WIDTH = 1,
    parameter int LANES = 2,
    parameter int DELAY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    connect_lane_reducer_if.slave bus
);
    localparam logic [1:0] c_MODE_OR     = 2'd0;
    localparam logic [1:0] c_MODE_AND    = 2'd1;
    localparam logic [1:0] c_MODE_XOR    = 2'd2;
    localparam logic [1:0] c_MODE_BYPASS = 2'd3;
    localparam logic [WIDTH-1:0] c_ONES  = {WIDTH{1'b1}};

    logic             w_acc;
    logic             w_fire;
    logic [WIDTH-1:0] w_ident;
    logic [WIDTH-1:0] w_lane_term [LANES];
    logic [WIDTH-1:0] w_red;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_result;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_bits_q,  out_bits_d;
    logic [15:0]      beats_q,     beats_d;
    logic [WIDTH-1:0] hist_q [DELAY];
    logic [WIDTH-1:0] hist_d [DELAY];

    // Handshakes: ready is combinational so a held result can be replaced in
    // the same cycle it is consumed.
    assign bus.io_in_ready = !out_valid_q || bus.io_out_ready;
    assign w_acc           = bus.io_in_valid && bus.io_in_ready;
    assign w_fire          = out_valid_q && bus.io_out_ready;

    assign bus.io_out_valid = out_valid_q;
    assign bus.io_out_bits  = out_bits_q;
    assign bus.io_beats     = beats_q;

    // A disabled lane must not disturb the reduction, so it presents the
    // identity of the selected operator.
    assign w_ident = (bus.io_mode == c_MODE_AND) ? c_ONES : '0;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_lane_term[gi] = bus.io_lane_en[gi] ? bus.io_in_bits : w_ident;
    end

    // Bitwise reduction of every lane term under the selected operator.
    always_comb begin
        w_red = w_ident;
        for (int i = 0; i < LANES; i++) begin
            case (bus.io_mode)
                c_MODE_AND: w_red = w_red & w_lane_term[i];
                c_MODE_XOR: w_red = w_red ^ w_lane_term[i];
                default:    w_red = w_red | w_lane_term[i];
            endcase
        end
    end

    assign w_x = hist_q[DELAY-1];

    // Combine the lane reduction with the oldest history entry.
    always_comb begin
        w_result = w_red | w_x;
        case (bus.io_mode)
            c_MODE_OR:     w_result = w_red | w_x;
            c_MODE_AND:    w_result = w_red & w_x;
            c_MODE_XOR:    w_result = w_red ^ w_x;
            c_MODE_BYPASS: w_result = bus.io_in_bits;
            default:       w_result = w_red | w_x;
        endcase
    end

    // Next-state: history ages only on accept; output register loads on accept
    // and empties on a consume with no replacement.
    always_comb begin
        hist_d      = hist_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        beats_d     = beats_q + 16'(w_fire);
        if (w_acc) begin
            hist_d[0] = bus.io_in_bits;
            for (int i = 1; i < DELAY; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            out_valid_d = 1'b1;
            out_bits_d  = w_result;
        end else if (w_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            beats_q     <= '0;
            for (int i = 0; i < DELAY; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            beats_q     <= beats_d;
            for (int i = 0; i < DELAY; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_connect_lane_reducer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_connect_lane_reducer
//  Brief    : Two instances (DELAY=1 and DELAY=3) driven by identical stimulus,
//             checked every cycle against a queue-based behavioural model plus
//             directed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_connect_lane_reducer;
    localparam int WIDTH = 8;
    localparam int LANES = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_bits = 8'h00;
    logic [1:0] mode = 2'd0;
    logic [1:0] lane_en = 2'b11;
    logic       out_ready = 1'b0;

    int total = 0;
    int bad = 0;

    // Model state.
    logic       m_valid = 1'b0;
    logic [7:0] m_bits1 = 8'h00;
    logic [7:0] m_bits3 = 8'h00;
    logic [15:0] m_beats = 16'h0;
    logic [7:0] acc_q[$];

    always #5 clk = ~clk;

    connect_lane_reducer_if #(.WIDTH(WIDTH), .LANES(LANES)) bus1 ();
    connect_lane_reducer_if #(.WIDTH(WIDTH), .LANES(LANES)) bus3 ();

    assign bus1.io_in_valid  = in_valid;
    assign bus1.io_in_bits   = in_bits;
    assign bus1.io_mode      = mode;
    assign bus1.io_lane_en   = lane_en;
    assign bus1.io_out_ready = out_ready;
    assign bus3.io_in_valid  = in_valid;
    assign bus3.io_in_bits   = in_bits;
    assign bus3.io_mode      = mode;
    assign bus3.io_lane_en   = lane_en;
    assign bus3.io_out_ready = out_ready;

    connect_lane_reducer #(.WIDTH(WIDTH), .LANES(LANES), .DELAY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    connect_lane_reducer #(.WIDTH(WIDTH), .LANES(LANES), .DELAY(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result from the operator rules: k enabled copies of the input reduced,
    // then combined with x.
    function automatic logic [7:0] model_result(input logic [1:0] md, input logic [1:0] en,
                                                input logic [7:0] din, input logic [7:0] x);
        int k;
        logic [7:0] red;
        k = int'(en[0]) + int'(en[1]);
        case (md)
            2'd0: begin red = (k > 0) ? din : 8'h00; return red | x; end
            2'd1: begin red = (k > 0) ? din : 8'hFF; return red & x; end
            2'd2: begin red = (k % 2 == 1) ? din : 8'h00; return red ^ x; end
            default: return din;
        endcase
    endfunction

    function automatic logic [7:0] hist_x(input int d);
        int n;
        n = acc_q.size();
        return (n >= d) ? acc_q[n-d] : 8'h00;
    endfunction

    // Model update on each rising edge.
    always @(posedge clk) begin
        logic acc, fire;
        if (reset) begin
            m_valid = 1'b0;
            m_bits1 = 8'h00;
            m_bits3 = 8'h00;
            m_beats = 16'h0;
            acc_q.delete();
        end else begin
            acc  = in_valid && (!m_valid || out_ready);
            fire = m_valid && out_ready;
            if (fire) m_beats = m_beats + 16'd1;
            if (acc) begin
                m_bits1 = model_result(mode, lane_en, in_bits, hist_x(1));
                m_bits3 = model_result(mode, lane_en, in_bits, hist_x(3));
                acc_q.push_back(in_bits);
                m_valid = 1'b1;
            end else if (fire) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("valid1", {31'b0, bus1.io_out_valid}, {31'b0, m_valid});
        chk("valid3", {31'b0, bus3.io_out_valid}, {31'b0, m_valid});
        chk("bits1", {24'b0, bus1.io_out_bits}, {24'b0, m_bits1});
        chk("bits3", {24'b0, bus3.io_out_bits}, {24'b0, m_bits3});
        chk("beats1", {16'b0, bus1.io_beats}, {16'b0, m_beats});
        chk("beats3", {16'b0, bus3.io_beats}, {16'b0, m_beats});
        chk("ready1", {31'b0, bus1.io_in_ready}, {31'b0, !m_valid || out_ready});
        chk("ready3", {31'b0, bus3.io_in_ready}, {31'b0, !m_valid || out_ready});
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_bits  = 8'($urandom);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] md, input logic [1:0] en);
        in_valid  = 1'b1;
        in_bits   = d;
        mode      = md;
        lane_en   = en;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    initial begin
        do_reset();
        out_ready = 1'b0;
        #1;
        chk("lit_rst_valid", {31'b0, bus1.io_out_valid}, 32'd0);
        chk("lit_rst_bits", {24'b0, bus1.io_out_bits}, 32'h00);
        chk("lit_rst_beats", {16'b0, bus1.io_beats}, 32'd0);
        chk("lit_rst_ready", {31'b0, bus1.io_in_ready}, 32'd1);

        // OR, both lanes.
        send(8'h0F, 2'd0, 2'b11);
        chk("lit_or_1", {24'b0, bus1.io_out_bits}, 32'h0F);
        send(8'hF0, 2'd0, 2'b11);
        chk("lit_or_2", {24'b0, bus1.io_out_bits}, 32'hFF);
        @(posedge clk);
        #1;
        chk("lit_or_beats", {16'b0, bus1.io_beats}, 32'd2);

        // XOR: both lanes cancel; then single lane.
        do_reset();
        send(8'h5A, 2'd2, 2'b11);
        chk("lit_xor_1", {24'b0, bus1.io_out_bits}, 32'h00);
        send(8'h5A, 2'd2, 2'b11);
        chk("lit_xor_2", {24'b0, bus1.io_out_bits}, 32'h5A);
        do_reset();
        send(8'h5A, 2'd2, 2'b11);
        send(8'h5A, 2'd2, 2'b01);
        chk("lit_xor_1lane", {24'b0, bus1.io_out_bits}, 32'h00);

        // AND with no lanes enabled: output equals history.
        do_reset();
        send(8'h3C, 2'd1, 2'b00);
        chk("lit_and_1", {24'b0, bus1.io_out_bits}, 32'h00);
        send(8'hFF, 2'd1, 2'b00);
        chk("lit_and_2", {24'b0, bus1.io_out_bits}, 32'h3C);

        // Backpressure, with mode/mask wiggling while held.
        do_reset();
        send(8'h11, 2'd0, 2'b11);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bits   = 8'h22;
        for (int i = 0; i < 3; i++) begin
            mode    = 2'(i + 1);
            lane_en = 2'(i);
            #1;
            chk("lit_bp_ready", {31'b0, bus1.io_in_ready}, 32'd0);
            chk("lit_bp_hold", {24'b0, bus1.io_out_bits}, 32'h11);
            @(posedge clk);
            #1;
        end
        mode      = 2'd0;
        lane_en   = 2'b11;
        out_ready = 1'b1;
        #1;
        chk("lit_bp_release_ready", {31'b0, bus1.io_in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lit_bp_valid", {31'b0, bus1.io_out_valid}, 32'd1);
        chk("lit_bp_bits", {24'b0, bus1.io_out_bits}, 32'h33);
        chk("lit_bp_beats", {16'b0, bus1.io_beats}, 32'd1);

        // DELAY=3 instance, OR with no lanes, then reset mid-stream.
        do_reset();
        send(8'h01, 2'd0, 2'b00);
        chk("lit_d3_1", {24'b0, bus3.io_out_bits}, 32'h00);
        send(8'h02, 2'd0, 2'b00);
        chk("lit_d3_2", {24'b0, bus3.io_out_bits}, 32'h00);
        send(8'h04, 2'd0, 2'b00);
        chk("lit_d3_3", {24'b0, bus3.io_out_bits}, 32'h00);
        send(8'h08, 2'd0, 2'b00);
        chk("lit_d3_4", {24'b0, bus3.io_out_bits}, 32'h01);
        do_reset();
        chk("lit_d3_rst_valid", {31'b0, bus3.io_out_valid}, 32'd0);
        chk("lit_d3_rst_beats", {16'b0, bus3.io_beats}, 32'd0);
        send(8'h10, 2'd0, 2'b00);
        chk("lit_d3_after_rst", {24'b0, bus3.io_out_bits}, 32'h00);

        // Randomized traffic, occasional reset.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_bits   = 8'($urandom);
            mode      = 2'($urandom);
            lane_en   = 2'($urandom);
            reset     = ($urandom % 250) == 0;
            @(posedge clk);
            #1;
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #6;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/connect_lane_reducer.md
# connect_lane_reducer

Parametrised successor to the two-lane OR-combiner test block. The input word is fanned out to LANES pass-through lanes, and the enabled lanes are reduced with a selectable operator. The reduction is combined with a DELAY-deep history of past accepted inputs, and the result is registered behind a ready/valid output stage. It sits in the connect/instance-wiring test suite as the multi-lane, multi-mode, flow-controlled generation of that block.

## Interface
Parameters:
- WIDTH, 1: data width in bits, ≥1.
- LANES, 2: number of pass-through lane instances, ≥1.
- DELAY, 1: history depth in accepted beats, ≥1.

Ports (clock `clk`, reset `reset`; one clock; reset is synchronous and active-high):
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- io_in_valid  in  1  input beat offered.
- io_in_ready  out  1  block can accept a beat this cycle.
- io_in_bits  in  WIDTH  input data.
- io_mode  in  2  operator: 0 = OR, 1 = AND, 2 = XOR, 3 = BYPASS; sampled on accept.
- io_lane_en  in  LANES  per-lane enable mask; sampled on accept.
- io_out_valid  out  1  output register holds a result.
- io_out_ready  in  1  consumer takes the result.
- io_out_bits  out  WIDTH  registered result.
- io_beats  out  16  count of completed output handshakes, wraps.

## Operation
- Accept: `acc = io_in_valid & io_in_ready`. Output handshake: `fire = io_out_valid & io_out_ready`.
- `io_in_ready = !io_out_valid | io_out_ready`. This is combinational, giving a single-stage pipe with no bubble.
- Each lane i outputs `lane[i] = io_in_bits`, the pass-through sub-instance. When `io_lane_en[i]=0`, lane i contributes the operator identity: 0 for OR and XOR, all-ones for AND.
- `red` = bitwise reduce of all LANES lane terms under io_mode.
- `hist` is a DELAY-entry shift register of WIDTH bits. It shifts only on `acc`: entry 0 takes io_in_bits. `x` = oldest entry, i.e. the value accepted DELAY accepts earlier, or 0 if fewer accepts have occurred since reset.
- Result:
  - OR: `red | x`.
  - AND: `red & x`.
  - XOR: `red ^ x`.
  - BYPASS: io_in_bits, with lanes and x ignored. The history still shifts.
- On `acc`: io_out_bits ← result and io_out_valid ← 1.
- On `fire` without `acc`: io_out_valid ← 0 and io_out_bits holds its value.
- On `fire` and `acc` in the same cycle: the new result replaces the old one and io_out_valid stays 1.
- io_beats increments on each `fire`, wrapping 0xFFFF → 0x0000.
- All lanes disabled: red = identity, so the result is `x` for OR, AND and XOR.
- No operating mode changes without an accept; mode/mask changes while a result is held do not alter io_out_bits.

## Timing
- Reset values: io_out_valid = 0, io_out_bits = 0, all hist entries = 0, io_beats = 0. io_in_ready is therefore 1 in the first cycle after reset.
- Reset asserted mid-operation: any pending output is dropped, history is cleared and the count is cleared, all at the next edge. An input offered while reset is high is not accepted and does not shift hist.
- Latency: 1 cycle from accept edge to io_out_valid high with that beat's result.
- Throughput: 1 beat/cycle while io_out_ready = 1.
- Backpressure: while io_out_valid = 1 and io_out_ready = 0, io_in_ready = 0 and io_out_bits is held stable.
- History indexing counts accepted beats only; stalled cycles do not age hist.

## Test plan
All scenarios use WIDTH=8, LANES=2, DELAY=1 unless stated.
- Reset then idle → io_out_valid=0, io_out_bits=0x00, io_beats=0, io_in_ready=1.
- OR mode, lane_en=2'b11, out_ready=1. Send 0x0F then 0xF0 → outputs 0x0F (x=0), then 0xFF (0xF0|0x0F). io_beats=2.
- XOR mode, lane_en=2'b11, send 0x5A twice → first output 0x00 (lanes cancel, x=0), second 0x5A (0 ^ x=0x5A). With lane_en=2'b01 the second output is 0x00.
- AND mode, lane_en=2'b00. Send 0x3C then 0xFF → outputs 0x00, then 0x3C (output = x).
- Backpressure: out_ready=0 after the first accept of 0x11, keep offering 0x22 for 3 cycles → io_in_ready=0, io_out_bits stays 0x11, hist not shifted. Raise out_ready → 0x11 fires and 0x22 is accepted in the same cycle, io_out_valid stays 1.
- DELAY=3, OR mode, lane_en=2'b00. Send 0x01, 0x02, 0x04, 0x08 → outputs 0x00, 0x00, 0x00, 0x01. Assert reset mid-stream → next output after reset is 0x00 and io_beats=0.
